access_code_entry: RTL
======================

ACCESS_CODE_ENTRY -- requirements
Module: access_code_entry

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: idle cycles between keys before the partial entry is discarded.
REQ-002 SHALL have parameter HOLD_CYCLES, default 8: cycles the submitted code is presented downstream.
REQ-003 SHALL have parameter MAX_FAIL, default 3: consecutive rejected codes before lockout.
REQ-004 SHALL have parameter LOCK_CYCLES, default 32: lockout duration in cycles.
REQ-005 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port key_valid  input  1  one-cycle strobe; key_digit is valid.
REQ-008 SHALL have port key_digit  input  4  keypad digit, legal values 0-9 (BCD).
REQ-009 SHALL have port key_clear  input  1  discard the partial entry.
REQ-010 SHALL have port key_enter  input  1  submit the entry.
REQ-011 SHALL have port door  input  1  accept result from the downstream security core (1 = code accepted).
REQ-012 SHALL have port access_code  output  12  three BCD digits, first-entered digit in [11:8], driven to the security core.
REQ-013 SHALL have port code_valid  output  1  high for every HOLD cycle.
REQ-014 SHALL have port digit_count  output  2  digits captured so far (0-3).
REQ-015 SHALL have port entry_error  output  1  one-cycle pulse on an illegal key event.
REQ-016 SHALL have port lockout  output  1  high while in LOCKOUT.

Function
REQ-017 SHALL implement the states IDLE, ENTRY, HOLD, LOCKOUT.
REQ-018 SHALL, in IDLE/ENTRY, on key_valid with key_digit<=9 and digit_count<3, shift the digit into the internal buffer (buf = {buf[7:0], digit}), increment digit_count, enter ENTRY, and restart the timeout counter.
REQ-019 SHALL treat key_valid with key_digit>9, or with digit_count==3, as illegal: buffer unchanged, entry_error pulses the next cycle.
REQ-020 SHALL, on key_enter with digit_count==3, load access_code from buf, clear buf and digit_count, and enter HOLD on the next edge.
REQ-021 SHALL, on key_enter with digit_count<3, pulse entry_error, clear buf and digit_count, and return to IDLE.
REQ-022 SHALL give key_clear priority over key_enter, and key_enter priority over key_valid, when they coincide; key_clear clears buf and digit_count and returns to IDLE without raising an error.
REQ-023 SHALL, in ENTRY, clear buf and digit_count and return to IDLE once TIMEOUT consecutive cycles pass without key_valid/key_enter/key_clear.
REQ-024 SHALL hold access_code for exactly HOLD_CYCLES cycles in HOLD, then drive 12'h000 and return to IDLE.
REQ-025 SHALL sample door on the first HOLD cycle: 1 clears the fail counter, 0 increments it.
REQ-026 SHALL, when the fail counter reaches MAX_FAIL, go from HOLD to LOCKOUT after HOLD completes, with the counter cleared on entry to LOCKOUT.
REQ-027 SHALL ignore all key inputs in HOLD and LOCKOUT, with no entry_error.
REQ-028 SHALL leave LOCKOUT for IDLE after exactly LOCK_CYCLES cycles.
REQ-029 SHALL drive access_code 12'h000 in every state except HOLD.
REQ-030 SHALL make all outputs registered, with no combinational path from inputs to outputs.

Reset
REQ-031 SHALL, on rst assertion at any time (including mid-entry, HOLD or LOCKOUT), force state=IDLE, access_code=12'h000, code_valid=0, digit_count=0, entry_error=0, lockout=0, and clear buf, the fail counter, the timeout counter and the hold/lock counters.
REQ-032 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification
REQ-033 SHALL verify: keys 1,2,3 then enter, door=1 -> access_code=12'h123 and code_valid high for 8 cycles, then 12'h000; fail counter remains 0.
REQ-034 SHALL verify: keys 7,3 then enter -> entry_error pulses once, digit_count=0, no HOLD.
REQ-035 SHALL verify: key 12 -> entry_error pulse with buffer unchanged; keys 2,9,4,5 -> fourth digit rejected, code stays 12'h294.
REQ-036 SHALL verify: key 1, then 16 idle cycles -> digit_count returns to 0; key_clear coinciding with key_enter -> IDLE with no error.
REQ-037 SHALL verify: three submissions of 12'h731 with door=0 -> lockout high for 32 cycles after the third HOLD, with keys ignored throughout; IDLE afterwards.
REQ-038 SHALL verify: rst asserted mid-HOLD -> access_code=12'h000 and code_valid=0 immediately (asynchronously); fail counter cleared.

Source files
------------

// File: rtl/access_code_entry.sv
// Keypad front end: collects three BCD digits, presents the submitted code to the
// security core for a fixed window, and locks the keypad after repeated rejections.
module access_code_entry #(
    parameter int TIMEOUT     = 16,
    parameter int HOLD_CYCLES = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    input  logic        key_clear,
    input  logic        key_enter,
    input  logic        door,
    output logic [11:0] access_code,
    output logic        code_valid,
    output logic [1:0]  digit_count,
    output logic        entry_error,
    output logic        lockout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int LW = $clog2(LOCK_CYCLES + 1);
    localparam int FW = $clog2(MAX_FAIL + 1);

    typedef enum logic [1:0] {IDLE, ENTRY, HOLD, LOCKOUT} state_t;

    state_t        state_q, state_d;
    logic [11:0]   buf_q, buf_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [11:0]   code_q, code_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          lockout_q, lockout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            hold_q    <= '0;
            lock_q    <= '0;
            fail_q    <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            hold_q    <= hold_d;
            lock_q    <= lock_d;
            fail_q    <= fail_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            lockout_q <= lockout_d;
        end
    end

    // Outputs are registered as the value the next state will present.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        hold_d    = hold_q;
        lock_d    = lock_q;
        fail_d    = fail_q;
        code_d    = '0;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        lockout_d = 1'b0;
        case (state_q)
            IDLE, ENTRY: begin
                if (key_clear) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    state_d = IDLE;
                end else if (key_enter) begin
                    buf_d = '0;
                    cnt_d = '0;
                    tmo_d = '0;
                    if (cnt_q == 2'd3) begin
                        code_d  = buf_q;
                        valid_d = 1'b1;
                        hold_d  = '0;
                        state_d = HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (key_valid) begin
                    tmo_d = '0;
                    if (key_digit <= 4'd9 && cnt_q != 2'd3) begin
                        buf_d   = {buf_q[7:0], key_digit};
                        cnt_d   = cnt_q + 2'd1;
                        state_d = ENTRY;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (state_q == ENTRY) begin
                    if (tmo_q == TW'(TIMEOUT - 1)) begin
                        buf_d   = '0;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        state_d = IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // The core's verdict is taken once, on the first cycle of the window.
                if (hold_q == '0) begin
                    fail_d = door ? '0 : fail_q + 1'b1;
                end
                if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                    hold_d = '0;
                    if (fail_d >= FW'(MAX_FAIL)) begin
                        fail_d    = '0;
                        lock_d    = '0;
                        lockout_d = 1'b1;
                        state_d   = LOCKOUT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d  = hold_q + 1'b1;
                    code_d  = code_q;
                    valid_d = 1'b1;
                end
            end
            LOCKOUT: begin
                if (lock_q == LW'(LOCK_CYCLES - 1)) begin
                    lock_d  = '0;
                    state_d = IDLE;
                end else begin
                    lock_d    = lock_q + 1'b1;
                    lockout_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign access_code = code_q;
    assign code_valid  = valid_q;
    assign digit_count = cnt_q;
    assign entry_error = err_q;
    assign lockout     = lockout_q;

endmodule
